// File: rtl/rdout_acc.sv
// Readout accumulator: sums per-lane PE partial dot products over one frame
// and holds the result on a valid/ready port. Macro: RDOUT_ACC_SAT_EN.
module rdout_acc #(
  parameter int QW     = 32,
  parameter int OUTS   = 2,
  parameter int NCHUNK = 16,
  parameter int PE_LAT = 3,
  parameter int ACCW   = QW + $clog2(NCHUNK)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [QW*OUTS-1:0] q_in,
  output logic [QW*OUTS-1:0] y,
  output logic             y_valid,
  input  logic             y_ready,
  output logic             busy
);

  localparam int CW = $clog2(NCHUNK + 1);

  typedef enum logic [1:0] {
    IDLE,
    ACC,
    HOLD
  } state_t;

  state_t state, state_nxt;

  logic [CW-1:0]     issue_cnt;
  logic [CW-1:0]     acc_cnt;
  logic [PE_LAT-1:0] tok_sr;
  logic              tok;
  logic              issue;
  logic              take;
  logic              last;
  logic              hs;

  logic [ACCW-1:0]    acc     [OUTS];
  logic [ACCW-1:0]    acc_nxt [OUTS];
  logic [QW*OUTS-1:0] y_nxt;

  assign in_ready = issue_cnt < CW'(NCHUNK);
  assign issue    = in_valid && in_ready;
  assign tok      = tok_sr[PE_LAT-1];
  assign take     = tok && (state == ACC);
  assign last     = take && (acc_cnt == CW'(NCHUNK - 1));
  assign y_valid  = (state == HOLD);
  assign hs       = y_valid && y_ready;
  assign busy     = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (issue) state_nxt = ACC;
      ACC:  if (last)  state_nxt = HOLD;
      HOLD: if (hs)    state_nxt = IDLE;
      default:         state_nxt = IDLE;
    endcase
  end

  // lanes are summed independently; sign extension keeps them carry-free
  always_comb begin
    for (int k = 0; k < OUTS; k++) begin
      acc_nxt[k] = acc[k] + {{(ACCW-QW){q_in[k*QW+QW-1]}},
                             q_in[k*QW +: QW]};
    end
  end

  always_comb begin
    y_nxt = '0;
    for (int k = 0; k < OUTS; k++) begin
`ifdef RDOUT_ACC_SAT_EN
      if (&acc_nxt[k][ACCW-1:QW-1] ||
          ~|acc_nxt[k][ACCW-1:QW-1]) begin
        y_nxt[k*QW +: QW] = acc_nxt[k][QW-1:0];
      end else if (acc_nxt[k][ACCW-1]) begin
        y_nxt[k*QW +: QW] = {1'b1, {(QW-1){1'b0}}};
      end else begin
        y_nxt[k*QW +: QW] = {1'b0, {(QW-1){1'b1}}};
      end
`else
      y_nxt[k*QW +: QW] = acc_nxt[k][QW-1:0];
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      issue_cnt <= '0;
      acc_cnt   <= '0;
      tok_sr    <= '0;
      y         <= '0;
      for (int k = 0; k < OUTS; k++) begin
        acc[k] <= '0;
      end
    end else begin
      tok_sr <= (tok_sr << 1) | PE_LAT'(issue);
      if (hs) begin
        issue_cnt <= '0;
        acc_cnt   <= '0;
        for (int k = 0; k < OUTS; k++) begin
          acc[k] <= '0;
        end
      end else begin
        if (issue) begin
          issue_cnt <= issue_cnt + CW'(1);
        end
        if (take) begin
          acc_cnt <= acc_cnt + CW'(1);
          for (int k = 0; k < OUTS; k++) begin
            acc[k] <= acc_nxt[k];
          end
        end
        if (last) begin
          y <= y_nxt;
        end
      end
    end
  end

endmodule

// File: tb/tb_rdout_acc.sv
// Directed bench for rdout_acc with NCHUNK=4, PE_LAT=2.
// Q lanes are driven only on token cycles; other cycles carry junk.
module tb_rdout_acc;

  localparam int QW = 32;
  localparam int OUTS = 2;
  localparam int NCH = 4;
  localparam int LAT = 2;

  logic          clk;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [63:0]   q_in;
  logic [63:0]   y;
  logic          y_valid;
  logic          y_ready;
  logic          busy;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] v0 [4];
  logic [31:0] v1 [4];

  rdout_acc #(
    .QW(QW), .OUTS(OUTS), .NCHUNK(NCH), .PE_LAT(LAT)
  ) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .q_in(q_in), .y(y),
    .y_valid(y_valid), .y_ready(y_ready),
    .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      in_valid = 1'b0;
      q_in = {32'h0BAD_0000 | i, 32'h0F00_0000 | i};
      tick();
    end
  endtask

  task automatic frame(input logic [15:0] mask,
                       input int hold_lo,
                       input bit yr_early,
                       input logic [31:0] e0,
                       input logic [31:0] e1,
                       input int exp_cyc,
                       input string tag);
    int tq[$];
    int k;
    int n_iss;
    bit done;
    k = 0;
    n_iss = 0;
    done = 1'b0;
    y_ready = yr_early;
    for (int c = 0; c < 64 && !done; c++) begin
      in_valid = (c < 16) ? mask[c] : 1'b0;
      q_in = {32'h1234_0000 | c, 32'h5678_0000 | c};
      if (tq.size() > 0 && tq[0] == c) begin
        if (k < 4) q_in = {v1[k], v0[k]};
        k++;
        void'(tq.pop_front());
      end
      if (y_valid) begin
        done = 1'b1;
        check({tag, "/vcyc"}, 64'(c), 64'(exp_cyc));
        check({tag, "/y"}, y, {e1, e0});
        if (!yr_early) begin
          for (int h = 0; h < hold_lo; h++) begin
            in_valid = 1'b1;
            q_in = {32'h7777_0000 | h, 32'h3333_0000 | h};
            check({tag, "/hold_rdy"}, in_ready, 1'b0);
            check({tag, "/hold_vld"}, y_valid, 1'b1);
            check({tag, "/hold_y"}, y, {e1, e0});
            tick();
          end
          y_ready = 1'b1;
        end
        tick();
        y_ready = 1'b0;
        in_valid = 1'b0;
        check({tag, "/post_vld"}, y_valid, 1'b0);
        check({tag, "/post_busy"}, busy, 1'b0);
        check({tag, "/post_rdy"}, in_ready, 1'b1);
      end else begin
        check({tag, "/in_ready"}, in_ready, n_iss < NCH);
        if (in_valid && in_ready) begin
          tq.push_back(c + LAT);
          n_iss++;
        end
        tick();
      end
    end
    if (!done) check({tag, "/timeout"}, 64'd0, 64'd1);
  endtask

  initial begin
    rst = 1'b1;
    in_valid = 1'b0;
    y_ready = 1'b0;
    q_in = 64'hFFFF_0000_AAAA_5555;
    tick();
    tick();
    rst = 1'b0;
    check("rst/y", y, 64'd0);
    check("rst/y_valid", y_valid, 1'b0);
    check("rst/busy", busy, 1'b0);
    check("rst/in_ready", in_ready, 1'b1);
    idle(3);

    v0 = '{32'd1, 32'd2, 32'd3, 32'd4};
    v1 = '{32'hFFFF_FFFF, 32'hFFFF_FFFF,
           32'hFFFF_FFFF, 32'hFFFF_FFFF};
    frame(16'h000F, 1, 1'b0, 32'd10, 32'hFFFF_FFFC, 6, "b2b");
    idle(2);

    v0 = '{32'd5, 32'd5, 32'd5, 32'd5};
    v1 = '{32'd5, 32'd5, 32'd5, 32'd5};
    frame(16'h0219, 5, 1'b0, 32'd20, 32'd20, 12, "gap");

    v0 = '{32'd7, 32'd7, 32'd7, 32'd7};
    v1 = '{32'd7, 32'd7, 32'd7, 32'd7};
    frame(16'h000F, 0, 1'b1, 32'd28, 32'd28, 6, "rs1");
    v0 = '{32'd10, 32'd20, 32'd30, 32'd40};
    v1 = '{32'hFFFF_FFFE, 32'hFFFF_FFFE,
           32'hFFFF_FFFE, 32'hFFFF_FFFE};
    frame(16'h000F, 0, 1'b1, 32'd100, 32'hFFFF_FFF8, 6, "rs2");
    idle(2);

    v0 = '{32'h7FFF_FFFF, 32'h7FFF_FFFF,
           32'h7FFF_FFFF, 32'h7FFF_FFFF};
    v1 = '{32'h8000_0000, 32'h8000_0000,
           32'h8000_0000, 32'h8000_0000};
`ifdef RDOUT_ACC_SAT_EN
    frame(16'h000F, 0, 1'b0, 32'h7FFF_FFFF, 32'h8000_0000, 6, "ovf");
`else
    frame(16'h000F, 0, 1'b0, 32'hFFFF_FFFC, 32'h0000_0000, 6, "ovf");
`endif
    idle(1);

    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      q_in = {32'd1, 32'd1};
      tick();
    end
    in_valid = 1'b0;
    rst = 1'b1;
    q_in = {32'd1, 32'd1};
    tick();
    rst = 1'b0;
    check("mrst/y_valid", y_valid, 1'b0);
    check("mrst/busy", busy, 1'b0);
    check("mrst/in_ready", in_ready, 1'b1);
    idle(4);

    v0 = '{32'd1, 32'd1, 32'd1, 32'd1};
    v1 = '{32'd1, 32'd1, 32'd1, 32'd1};
    frame(16'h000F, 0, 1'b0, 32'd4, 32'd4, 6, "post_rst");
    idle(2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
